// File: rtl/sos_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade.
package sos_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCALE,
    ST_MAC0,
    ST_MAC1,
    ST_MAC2,
    ST_MAC3,
    ST_MAC4,
    ST_WRB,
    ST_DONE
  } sos_state_e;

  typedef enum logic [1:0] {
    MAC_HOLD,
    MAC_LOAD,
    MAC_ADD,
    MAC_SUB
  } mac_op_e;

  localparam int unsigned COEF_IDX_G  = 0;
  localparam int unsigned COEF_IDX_B0 = 1;
  localparam int unsigned COEF_IDX_B1 = 2;
  localparam int unsigned COEF_IDX_B2 = 3;
  localparam int unsigned COEF_IDX_A1 = 4;
  localparam int unsigned COEF_IDX_A2 = 5;
  localparam int unsigned COEF_NUM    = 6;

  // Five products summed: three guard bits keep the accumulator from wrapping.
  function automatic int unsigned acc_width(int unsigned data_size, int unsigned coef_size);
    return data_size + coef_size + 3;
  endfunction

  // Reset bank value: unity gain and unity B0, everything else zero.
  function automatic int passthrough_coef(int idx, int frac);
    return ((idx == int'(COEF_IDX_G)) || (idx == int'(COEF_IDX_B0))) ? (1 << frac) : 0;
  endfunction

endpackage

// File: rtl/sos_cascade_tdm_if.sv
// Sample, coefficient-write and status signals of the biquad cascade.
interface sos_cascade_tdm_if #(
  parameter int unsigned DATA_SIZE    = 24,
  parameter int unsigned COEF_SIZE    = 12,
  parameter int unsigned NUM_SECTIONS = 2
);
  localparam int unsigned ADDR_W = 4 + $clog2(NUM_SECTIONS);

  logic signed [DATA_SIZE-1:0] data_in;
  logic                        sample_trig;
  logic                        coef_we;
  logic [ADDR_W-1:0]           coef_addr;
  logic signed [COEF_SIZE-1:0] coef_wdata;
  logic                        state_clr;
  logic signed [DATA_SIZE-1:0] data_out;
  logic                        filter_done;
  logic                        busy;
  logic                        overrun;

  modport master (
    output data_in, sample_trig, coef_we, coef_addr, coef_wdata, state_clr,
    input  data_out, filter_done, busy, overrun
  );

  modport slave (
    input  data_in, sample_trig, coef_we, coef_addr, coef_wdata, state_clr,
    output data_out, filter_done, busy, overrun
  );
endinterface

// File: rtl/sos_mac_unit.sv
// Shared signed multiply-accumulate with round-half-up and saturation to sample width.
module sos_mac_unit
  import sos_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 24,
  parameter int unsigned COEF_SIZE = 12,
  parameter int unsigned COEF_FRAC = 8,
  parameter int unsigned ACC_W     = 39
) (
  input  logic                        clk,
  input  logic                        reset,
  input  mac_op_e                     op,
  input  logic signed [DATA_SIZE-1:0] a,
  input  logic signed [COEF_SIZE-1:0] b,
  output logic signed [DATA_SIZE-1:0] y_c
);
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({(DATA_SIZE-1){1'b1}});
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic signed [DATA_SIZE+COEF_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]               prod_x;
  logic signed [ACC_W-1:0]               acc_q;
  logic signed [ACC_W-1:0]               rnd;

  assign prod   = a * b;
  assign prod_x = ACC_W'(prod);
  assign rnd    = (acc_q + RND) >>> COEF_FRAC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      case (op)
        MAC_LOAD: acc_q <= prod_x;
        MAC_ADD:  acc_q <= acc_q + prod_x;
        MAC_SUB:  acc_q <= acc_q - prod_x;
        default:  acc_q <= acc_q;
      endcase
    end
  end

  always_comb begin
    y_c = rnd[DATA_SIZE-1:0];
    if (rnd > Y_MAX)      y_c = Y_MAX[DATA_SIZE-1:0];
    else if (rnd < Y_MIN) y_c = Y_MIN[DATA_SIZE-1:0];
  end
endmodule

// File: rtl/sos_cascade_tdm.sv
// Cascade of Direct Form I biquads sharing one multiplier, seven cycles per section.
module sos_cascade_tdm
  import sos_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 24,
  parameter int unsigned COEF_SIZE    = 12,
  parameter int unsigned COEF_FRAC    = 8,
  parameter int unsigned NUM_SECTIONS = 2
) (
  input logic              clk,
  input logic              reset,
  sos_cascade_tdm_if.slave bus
);
  localparam int unsigned ACC_W  = acc_width(DATA_SIZE, COEF_SIZE);
  localparam int unsigned ADDR_W = 4 + $clog2(NUM_SECTIONS);
  localparam int unsigned SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

  typedef logic signed [DATA_SIZE-1:0] data_t;
  typedef logic signed [COEF_SIZE-1:0] coef_t;

  sos_state_e        state_q, state_d;
  logic [SEC_W-1:0]  sec_q;
  coef_t             coef_q [NUM_SECTIONS][COEF_NUM];
  data_t             x1_q [NUM_SECTIONS];
  data_t             x2_q [NUM_SECTIONS];
  data_t             y1_q [NUM_SECTIONS];
  data_t             y2_q [NUM_SECTIONS];
  data_t             x_q, u_q, mac_a, mac_y_c;
  coef_t             mac_b;
  mac_op_e           mac_op;
  logic              idle, last_sec, clr_ok, trig_ok, wr_ok;
  logic [3:0]        wr_idx;
  logic [ADDR_W-1:0] wr_sec;

  assign idle     = (state_q == ST_IDLE);
  assign last_sec = (sec_q == SEC_W'(NUM_SECTIONS - 1));
  assign clr_ok   = idle && bus.state_clr;
  assign trig_ok  = idle && bus.sample_trig && !bus.state_clr;
  assign wr_idx   = bus.coef_addr[3:0];
  assign wr_sec   = bus.coef_addr >> 4;
  assign wr_ok    = idle && bus.coef_we && (wr_idx < 4'(COEF_NUM)) &&
                    (wr_sec < ADDR_W'(NUM_SECTIONS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Sequencing and multiplier operand steering; MAC0 consumes the rounded scale result.
  always_comb begin
    state_d = state_q;
    mac_op  = MAC_HOLD;
    mac_a   = x_q;
    mac_b   = coef_q[sec_q][3'(COEF_IDX_G)];
    case (state_q)
      ST_IDLE:  if (trig_ok) state_d = ST_SCALE;
      ST_SCALE: begin
        mac_op  = MAC_LOAD;
        state_d = ST_MAC0;
      end
      ST_MAC0: begin
        mac_op  = MAC_LOAD;
        mac_a   = mac_y_c;
        mac_b   = coef_q[sec_q][3'(COEF_IDX_B0)];
        state_d = ST_MAC1;
      end
      ST_MAC1: begin
        mac_op  = MAC_ADD;
        mac_a   = x1_q[sec_q];
        mac_b   = coef_q[sec_q][3'(COEF_IDX_B1)];
        state_d = ST_MAC2;
      end
      ST_MAC2: begin
        mac_op  = MAC_ADD;
        mac_a   = x2_q[sec_q];
        mac_b   = coef_q[sec_q][3'(COEF_IDX_B2)];
        state_d = ST_MAC3;
      end
      ST_MAC3: begin
        mac_op  = MAC_SUB;
        mac_a   = y1_q[sec_q];
        mac_b   = coef_q[sec_q][3'(COEF_IDX_A1)];
        state_d = ST_MAC4;
      end
      ST_MAC4: begin
        mac_op  = MAC_SUB;
        mac_a   = y2_q[sec_q];
        mac_b   = coef_q[sec_q][3'(COEF_IDX_A2)];
        state_d = ST_WRB;
      end
      ST_WRB:  state_d = last_sec ? ST_DONE : ST_SCALE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  sos_mac_unit #(
    .DATA_SIZE(DATA_SIZE),
    .COEF_SIZE(COEF_SIZE),
    .COEF_FRAC(COEF_FRAC),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .op   (mac_op),
    .a    (mac_a),
    .b    (mac_b),
    .y_c  (mac_y_c)
  );

  // Coefficient bank, delay lines and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q           <= '0;
      x_q             <= '0;
      u_q             <= '0;
      bus.data_out    <= '0;
      bus.filter_done <= 1'b0;
      bus.busy        <= 1'b0;
      bus.overrun     <= 1'b0;
      for (int s = 0; s < int'(NUM_SECTIONS); s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
        for (int i = 0; i < int'(COEF_NUM); i++)
          coef_q[s][i] <= COEF_SIZE'(passthrough_coef(i, int'(COEF_FRAC)));
      end
    end else begin
      bus.filter_done <= 1'b0;
      if (bus.sample_trig && !idle) bus.overrun <= 1'b1;
      if (wr_ok) coef_q[wr_sec[SEC_W-1:0]][wr_idx[2:0]] <= bus.coef_wdata;
      if (clr_ok) begin
        bus.overrun <= 1'b0;
        for (int s = 0; s < int'(NUM_SECTIONS); s++) begin
          x1_q[s] <= '0;
          x2_q[s] <= '0;
          y1_q[s] <= '0;
          y2_q[s] <= '0;
        end
      end
      if (trig_ok) begin
        x_q      <= bus.data_in;
        sec_q    <= '0;
        bus.busy <= 1'b1;
      end
      case (state_q)
        ST_MAC0: u_q <= mac_y_c;
        ST_WRB: begin
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= u_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= mac_y_c;
          x_q         <= mac_y_c;
          if (last_sec) begin
            bus.data_out    <= mac_y_c;
            bus.filter_done <= 1'b1;
            bus.busy        <= 1'b0;
          end else begin
            sec_q <= sec_q + SEC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sos_cascade_tdm.sv
// Scoreboard bench for the biquad cascade: expected outputs queued at trigger, checked on filter_done.
module tb_sos_cascade_tdm;
  import sos_pkg::*;

  localparam int unsigned D      = 24;
  localparam int unsigned C      = 12;
  localparam int unsigned F      = 8;
  localparam int unsigned N      = 2;
  localparam int unsigned ADDR_W = 4 + $clog2(N);
  localparam int          LAT    = 7 * N + 1;
  localparam longint      NO_WANT = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam int K_NONE = 0, K_TRIG = 1, K_WR = 2, K_RST = 3, K_SAMEWR = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sos_cascade_tdm_if #(.DATA_SIZE(D), .COEF_SIZE(C), .NUM_SECTIONS(N)) bus ();

  sos_cascade_tdm #(
    .DATA_SIZE(D), .COEF_SIZE(C), .COEF_FRAC(F), .NUM_SECTIONS(N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int     n_vec = 0;
  int     n_err = 0;
  longint exp_q[$];
  longint m_coef [N][6];
  longint m_x1 [N], m_x2 [N], m_y1 [N], m_y2 [N];

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic longint rs(input longint v);
    longint r, hi;
    hi = (longint'(1) <<< (D - 1)) - 1;
    r  = (v + (longint'(1) <<< (F - 1))) >>> F;
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
    return r;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < N; s++) begin
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
  endfunction

  function automatic void model_reset();
    model_clear();
    for (int s = 0; s < N; s++)
      for (int i = 0; i < 6; i++) m_coef[s][i] = (i <= 1) ? (longint'(1) <<< F) : 0;
  endfunction

  function automatic void model_write(input int s, input int idx, input longint v);
    if (idx < 6 && s < N) m_coef[s][idx] = v;
  endfunction

  function automatic longint model_run(input longint d);
    longint x, u, acc, y;
    x = d;
    for (int s = 0; s < N; s++) begin
      u   = rs(x * m_coef[s][0]);
      acc = m_coef[s][1] * u + m_coef[s][2] * m_x1[s] + m_coef[s][3] * m_x2[s]
          - m_coef[s][4] * m_y1[s] - m_coef[s][5] * m_y2[s];
      y   = rs(acc);
      m_x2[s] = m_x1[s]; m_x1[s] = u; m_y2[s] = m_y1[s]; m_y1[s] = y;
      x = y;
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (reset && bus.filter_done) begin
      if (exp_q.size() == 0) check_val("spurious_done", 1, 0);
      else check_val("data_out", $signed(bus.data_out), exp_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic write_coef(input int s, input int idx, input longint v);
    @(posedge clk); #1;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = ADDR_W'((s << 4) | idx);
    bus.coef_wdata = C'(v);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    model_write(s, idx, v);
  endtask

  task automatic clear_state();
    @(posedge clk); #1;
    bus.state_clr = 1'b1;
    @(posedge clk); #1;
    bus.state_clr = 1'b0;
    model_clear();
  endtask

  // One sample with an optional disturbance injected evt_n cycles after the trigger.
  task automatic run_sample(input longint d, input longint want, input int kind, input int evt_n);
    int lat;
    bit seen;
    longint m;
    @(posedge clk); #1;
    bus.data_in     = D'(d);
    bus.sample_trig = 1'b1;
    if (kind == K_SAMEWR) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = ADDR_W'((1 << 4) | int'(COEF_IDX_G));
      bus.coef_wdata = C'(512);
      model_write(1, int'(COEF_IDX_G), 512);
    end
    if (kind != K_RST) begin
      m = model_run(d);
      exp_q.push_back((want == NO_WANT) ? m : want);
    end
    @(posedge clk); #1;
    bus.sample_trig = 1'b0;
    bus.coef_we     = 1'b0;
    lat  = -1;
    seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) check_val("busy_rise", bus.busy, 1);
      if (n == evt_n) begin
        if (kind == K_TRIG) bus.sample_trig = 1'b1;
        if (kind == K_RST) reset = 1'b0;
        if (kind == K_WR) begin
          bus.coef_we    = 1'b1;
          bus.coef_addr  = ADDR_W'(int'(COEF_IDX_B0));
          bus.coef_wdata = '0;
        end
      end
      if (n == evt_n + 1) begin
        bus.sample_trig = 1'b0;
        bus.coef_we     = 1'b0;
        if (kind == K_RST) begin
          check_val("abort_data_out", $signed(bus.data_out), 0);
          check_val("abort_busy", bus.busy, 0);
        end
      end
      if (kind == K_RST && n == evt_n + 3) reset = 1'b1;
      if (reset && bus.filter_done) begin
        lat  = n;
        seen = 1'b1;
        check_val("busy_fall", bus.busy, 0);
        break;
      end
    end
    if (kind == K_RST) check_val("abort_no_done", seen, 0);
    else check_val("latency", lat, LAT);
  endtask

  initial begin
    bus.data_in = '0; bus.sample_trig = 1'b0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_wdata = '0; bus.state_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_data_out", $signed(bus.data_out), 0);
    check_val("rst_done", bus.filter_done, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_overrun", bus.overrun, 0);
    reset = 1'b1;

    run_sample(64'sh1000, 64'sh1000, K_NONE, 0);
    run_sample(64'sh1000, 8192, K_SAMEWR, 0);
    write_coef(1, int'(COEF_IDX_G), 256);

    clear_state();
    write_coef(0, int'(COEF_IDX_B0), 128);
    write_coef(0, int'(COEF_IDX_A1), -128);
    run_sample(1000, 500, K_NONE, 0);
    run_sample(0, 250, K_NONE, 0);
    run_sample(0, 125, K_NONE, 0);
    run_sample(0, 63, K_NONE, 0);

    write_coef(0, int'(COEF_IDX_A1), 0);
    write_coef(0, int'(COEF_IDX_G), 1020);
    write_coef(0, int'(COEF_IDX_B0), 256);
    run_sample(64'sh400000, 64'sh7FFFFF, K_NONE, 0);
    run_sample(-64'sh400000, -64'sh800000, K_NONE, 0);

    write_coef(0, int'(COEF_IDX_G), 256);
    clear_state();
    run_sample(4096, 4096, K_TRIG, 5);
    repeat (20) @(posedge clk);
    #1 check_val("overrun_set", bus.overrun, 1);
    clear_state();
    #1 check_val("overrun_clr", bus.overrun, 0);
    write_coef(0, int'(COEF_IDX_B0), 128);
    write_coef(0, int'(COEF_IDX_A1), -128);
    run_sample(1000, 500, K_NONE, 0);
    clear_state();
    run_sample(0, 0, K_NONE, 0);
    write_coef(0, int'(COEF_IDX_B0), 256);
    write_coef(0, int'(COEF_IDX_A1), 0);

    clear_state();
    run_sample(4096, 4096, K_WR, 3);
    run_sample(4096, 4096, K_NONE, 0);
    write_coef(0, int'(COEF_IDX_B0), 0);
    run_sample(4096, 0, K_NONE, 0);
    write_coef(0, int'(COEF_IDX_B0), 256);

    @(posedge clk); #1;
    bus.state_clr = 1'b1; bus.sample_trig = 1'b1; bus.data_in = D'(777);
    @(posedge clk); #1;
    bus.state_clr = 1'b0; bus.sample_trig = 1'b0;
    model_clear();
    @(negedge clk);
    check_val("clr_beats_trig", bus.busy, 0);
    repeat (20) @(posedge clk);

    write_coef(1, int'(COEF_IDX_G), 512);
    run_sample(4096, 8192, K_NONE, 0);
    run_sample(4096, 0, K_RST, 4);
    model_reset();
    exp_q.delete();
    run_sample(4096, 4096, K_NONE, 0);

    clear_state();
    for (int k = 0; k < 6; k++)
      write_coef(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 5)),
                 longint'($urandom_range(0, 600)) - 300);
    write_coef(0, 9, 77);
    for (int k = 0; k < 8; k++)
      run_sample(longint'($urandom_range(0, 2097152)) - 1048576, NO_WANT, K_NONE, 0);

    repeat (20) @(posedge clk);
    check_val("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
